level_im_fetch: RTL and testbench
=================================

// Module: level_im_fetch
// PURPOSE
//  Parametrised, writable level item memory for the sparse HDC encoder. Accepts one sample of CH
//  quantised levels per valid/ready handshake. Emits the CH level hypervectors serially, one per
//  out-handshake, to the downstream binder/bundler. Replaces the fixed 10-entry combinational
//  lookup with a registered, back-pressured, runtime-loadable memory.
// PARAMETERS
//  HV_W    10                  hypervector width (bits)
//  LEVELS  10                  number of quantisation levels / memory entries
//  CH      4                   channels (levels) per input sample
//  QW      $clog2(LEVELS)      qlevel field width; derived, not overridden
//  CW      $clog2(CH) (min 1)  channel index width; derived
// PORTS
//  clk        in   1        clock, rising edge
//  nrst       in   1        reset, synchronous, active-low
//  wr_en      in   1        write item memory entry
//  wr_addr    in   QW       entry to write; writes with wr_addr>=LEVELS are ignored
//  wr_data    in   HV_W     hypervector to store
//  in_valid   in   1        sample valid
//  in_ready   out  1        sample accepted when in_valid&&in_ready
//  in_qlevel  in   CH*QW    channel c occupies bits [c*QW +: QW]
//  out_valid  out  1        out_hv valid
//  out_ready  in   1        downstream accepts beat when out_valid&&out_ready
//  out_hv     out  HV_W     level hypervector for channel out_ch
//  out_ch     out  CW       channel index of current beat
//  out_last   out  1        beat is channel CH-1
//  out_err    out  1        qlevel of this beat was >=LEVELS; out_hv forced to 0
// BEHAVIOUR
//  - Reset (nrst=0 at clk edge): state=IDLE; out_valid/out_last/out_err=0; out_hv=0; out_ch=0.
//    Memory reinitialised to mem[i]=i (zero-extended to HV_W). Reset aborts any sample in flight
//    with no further beats.
//  - FSM IDLE/EMIT. in_ready = (state==IDLE) || (out_valid && out_ready && out_last) (comb).
//  - IDLE: on accept, latch in_qlevel into sample buffer and load the ch0 beat; next cycle EMIT
//    with out_valid=1. Latency accept->first beat is 1 cycle.
//  - EMIT: out_* hold stable while out_valid && !out_ready.
//    Handshake with !out_last: load beat for ch+1 at the same edge.
//    Handshake with out_last: if in_valid, accept a new sample and load its ch0 beat, so
//    back-to-back samples run with no bubble (CH beats per CH cycles). Otherwise go to IDLE with
//    out_valid=0.
//  - Beat load: out_hv = mem[q], out_err=0 if q<LEVELS; else out_hv=0, out_err=1.
//    out_last = (ch==CH-1).
//  - Write port is independent of the FSM and takes effect at the edge it is sampled.
//    A beat loaded at the same edge reads pre-write contents. wr_en during reset is ignored.
//  - CH=1: every beat is last; the ready path degenerates to single-beat pass-through.
// CONFIGURATION
//  IM_PERMUTE_EN defined: loaded out_hv is rotated left by ch bits (rotate amount taken mod HV_W),
//    binding position into the level vector; out_err beats remain 0.
//  IM_PERMUTE_EN undefined: out_hv is the raw memory entry; no rotator is synthesised.
// STRUCTURE
//  - Package level_im_pkg holds:
//      default HV_W / LEVELS / CH constants;
//      typedef state_t {IDLE, EMIT};
//      function init_hv(i) returning the reset seed.
//  - Sub-module level_im_mem holds LEVELS x HV_W registers, sync write, comb read, sync reset
//    to seed. Top keeps the FSM, sample buffer, channel counter, optional rotator and output
//    registers.
// TESTING (HV_W=10, LEVELS=10, CH=4)
//  1. Reset: hold nrst=0 2 cycles -> in_ready=1, out_valid=0, out_hv=0. Sample {0,1,2,9} ->
//     beats 0x000, 0x001, 0x002, 0x009, out_last on beat 4.
//  2. Sample ch0..3 = {3,9,0,12} -> beats 0x003, 0x009, 0x000, 0x000; out_err=1 on beat 4 only;
//     out_ch 0,1,2,3.
//  3. Backpressure: out_ready=0 for 3 cycles mid-sample -> out_hv/out_ch/out_err stable;
//     in_ready=0; no beat lost or duplicated.
//  4. Write mem[5]=0x3FF, then sample {5,5,5,5} -> four beats of 0x3FF. Write mem[2]=0x155 in
//     the same cycle ch2 (q=2) is loaded -> old value 0x002 emitted.
//  5. Back-to-back: in_valid held high, out_ready=1 for 3 samples -> 12 consecutive valid beats,
//     no bubble. nrst=0 during beat 2 of sample 2 -> out_valid=0 next cycle; mem reseeded.
//  6. IM_PERMUTE_EN: sample {1,1,1,1} -> 0x001, 0x002, 0x004, 0x008; rerun without the macro ->
//     0x001 x4.

Source files
------------

// File: rtl/level_im_pkg.sv
// level_im_pkg: shared defaults, FSM encoding and memory reset seed for level_im_fetch.
package level_im_pkg;
   localparam int HV_W_DEF = 10;
   localparam int LEVELS_DEF = 10;
   localparam int CH_DEF = 4;
   typedef logic [0:0] state_t;
   localparam state_t IDLE = 1'b0;
   localparam state_t EMIT = 1'b1;
   function automatic logic [31:0] init_hv(input int i);
      return 32'(i);
   endfunction
endpackage

// File: rtl/level_im_mem.sv
// level_im_mem: LEVELS x HV_W level item memory, sync write, comb read, reset to seed.
module level_im_mem
   import level_im_pkg::*;
#(
   parameter int HV_W = HV_W_DEF,
   parameter int LEVELS = LEVELS_DEF,
   parameter int QW = (LEVELS > 1) ? $clog2(LEVELS) : 1
)(
   input  logic            clk,
   input  logic            nrst,
   input  logic            wr_en,
   input  logic [QW-1:0]   wr_addr,
   input  logic [HV_W-1:0] wr_data,
   input  logic [QW-1:0]   rd_addr,
   output logic [HV_W-1:0] rd_data
);
   logic [HV_W-1:0] mem [LEVELS];
   always_ff @(posedge clk)
      for (int i = 0; i < LEVELS; i++)
         if (!nrst) mem[i] <= HV_W'(init_hv(i));
         else if (wr_en && wr_addr == QW'(i)) mem[i] <= wr_data;
   assign rd_data = (32'(rd_addr) < LEVELS) ? mem[rd_addr] : '0;
endmodule

// File: rtl/level_im_fetch.sv
// level_im_fetch: writable level item memory emitting one hypervector beat per channel per sample.
// IM_PERMUTE_EN: rotate each loaded beat left by its channel index.
module level_im_fetch
   import level_im_pkg::*;
#(
   parameter int HV_W = HV_W_DEF,
   parameter int LEVELS = LEVELS_DEF,
   parameter int CH = CH_DEF,
   localparam int QW = (LEVELS > 1) ? $clog2(LEVELS) : 1,
   localparam int CW = (CH > 1) ? $clog2(CH) : 1
)(
   input  logic            clk,
   input  logic            nrst,
   input  logic            wr_en,
   input  logic [QW-1:0]   wr_addr,
   input  logic [HV_W-1:0] wr_data,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [CH*QW-1:0] in_qlevel,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [HV_W-1:0] out_hv,
   output logic [CW-1:0]   out_ch,
   output logic            out_last,
   output logic            out_err
);
   state_t state;
   logic [CH*QW-1:0] sbuf, src;
   logic hs, acc, ld, ld_err;
   logic [CW-1:0] nch;
   logic [QW-1:0] q;
   logic [HV_W-1:0] rd_hv, ld_hv;
   assign hs = out_valid && out_ready;
   assign in_ready = state == IDLE || (hs && out_last);
   assign acc = in_valid && in_ready;
   assign ld = acc || (hs && !out_last);
   // a fresh sample reads its channels straight from the input so ch0 loads at the accept edge
   assign nch = acc ? '0 : out_ch + CW'(1);
   assign src = acc ? in_qlevel : sbuf;
   assign q = src[int'(nch)*QW +: QW];
   assign ld_err = 32'(q) >= LEVELS;
   level_im_mem #(.HV_W(HV_W), .LEVELS(LEVELS), .QW(QW)) u_mem (
      .clk(clk),
      .nrst(nrst),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_addr(q),
      .rd_data(rd_hv)
   );
`ifdef IM_PERMUTE_EN
   logic [2*HV_W-1:0] dbl;
   assign dbl = {rd_hv, rd_hv} << (int'(nch) % HV_W);
   assign ld_hv = dbl[2*HV_W-1 -: HV_W];
`else
   assign ld_hv = rd_hv;
`endif
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state <= IDLE;
         sbuf <= '0;
         out_valid <= 1'b0;
         out_last <= 1'b0;
         out_err <= 1'b0;
         out_hv <= '0;
         out_ch <= '0;
      end else begin
         if (acc) sbuf <= in_qlevel;
         if (ld) begin
            state <= EMIT;
            out_valid <= 1'b1;
            out_ch <= nch;
            out_last <= nch == CW'(CH-1);
            out_hv <= ld_hv;
            out_err <= ld_err;
         end else if (hs) begin
            state <= IDLE;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            out_err <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_level_im_fetch.sv
// tb_level_im_fetch: directed samples with hand-computed beats checked by a queue-based monitor.
module tb_level_im_fetch;
   localparam int HV_W = 10, LEVELS = 10, CH = 4, QW = 4, CW = 2;
   logic clk = 0, nrst = 0, wr_en = 0;
   logic [QW-1:0] wr_addr = '0;
   logic [HV_W-1:0] wr_data = '0;
   logic in_valid = 0, in_ready;
   logic [CH*QW-1:0] in_qlevel = '0;
   logic out_valid, out_ready = 1, out_last, out_err;
   logic [HV_W-1:0] out_hv;
   logic [CW-1:0] out_ch;
   typedef struct {logic [HV_W-1:0] hv; logic [CW-1:0] ch; logic last; logic err;} beat_t;
   beat_t sb[$];
   int total = 0, bad = 0, run = 0;

   always #5 clk = ~clk;

   level_im_fetch dut (
      .clk(clk), .nrst(nrst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_qlevel(in_qlevel),
      .out_valid(out_valid), .out_ready(out_ready), .out_hv(out_hv), .out_ch(out_ch),
      .out_last(out_last), .out_err(out_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [HV_W-1:0] exp_hv(input int q, input int h, input int c);
      logic [HV_W-1:0] v = (q >= LEVELS) ? '0 : HV_W'(h);
      int n = 0;
`ifdef IM_PERMUTE_EN
      n = c % HV_W;
`endif
      for (int i = 0; i < n; i++) v = {v[HV_W-2:0], v[HV_W-1]};
      return v;
   endfunction

   // monitor: every valid cycle must match the queue head; pop on handshake
   always @(negedge clk) begin
      if (out_valid) begin
         if (sb.size() == 0) chk("unexpected_beat", 32'(sb.size()), 1);
         else begin
            chk("out_hv", 32'(out_hv), 32'(sb[0].hv));
            chk("out_ch", 32'(out_ch), 32'(sb[0].ch));
            chk("out_last", 32'(out_last), 32'(sb[0].last));
            chk("out_err", 32'(out_err), 32'(sb[0].err));
            if (out_ready) begin
               void'(sb.pop_front());
               run++;
            end
         end
      end else run = 0;
   end

   // called at posedge+1; returns at posedge+1 after the accepting edge, in_valid left high
   task automatic send(input int q0, q1, q2, q3, input int h0, h1, h2, h3);
      int q[CH] = '{q0, q1, q2, q3};
      int h[CH] = '{h0, h1, h2, h3};
      beat_t b;
      in_valid = 1;
      for (int c = 0; c < CH; c++) in_qlevel[c*QW +: QW] = QW'(q[c]);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            for (int c = 0; c < CH; c++) begin
               b.hv = exp_hv(q[c], h[c], c);
               b.ch = CW'(c);
               b.last = (c == CH-1);
               b.err = (q[c] >= LEVELS);
               sb.push_back(b);
            end
            @(posedge clk); #1;
            return;
         end
      end
      chk("accept_timeout", 32'(in_ready), 1);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && sb.size() != 0; i++) begin
         @(negedge clk); #1;
      end
      chk("drain_timeout", 32'(sb.size()), 0);
      @(posedge clk); #1;
   endtask

   task automatic write(input int a, input int d);
      wr_en = 1; wr_addr = QW'(a); wr_data = HV_W'(d);
      @(posedge clk); #1;
      wr_en = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      nrst = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_hv", 32'(out_hv), 0);
      chk("rst_out_ch", 32'(out_ch), 0);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_out_err", 32'(out_err), 0);
      nrst = 1;
      @(posedge clk); #1;
      send(0, 1, 2, 9, 'h000, 'h001, 'h002, 'h009);
      in_valid = 0;
      drain();
      send(3, 9, 0, 12, 'h003, 'h009, 'h000, 'h000);
      in_valid = 0;
      drain();
      send(1, 2, 3, 4, 1, 2, 3, 4);
      in_valid = 0;
      @(posedge clk); #1;
      out_ready = 0;
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(in_ready), 0);
      end
      @(posedge clk); #1;
      out_ready = 1;
      drain();
      write(5, 'h3FF);
      send(5, 5, 5, 5, 'h3FF, 'h3FF, 'h3FF, 'h3FF);
      in_valid = 0;
      drain();
      send(0, 1, 2, 3, 'h000, 'h001, 'h002, 'h003);
      in_valid = 0;
      @(posedge clk); #1;
      write(2, 'h155);
      drain();
      send(2, 2, 2, 2, 'h155, 'h155, 'h155, 'h155);
      in_valid = 0;
      drain();
      send(0, 1, 3, 4, 0, 1, 3, 4);
      send(6, 7, 8, 9, 6, 7, 8, 9);
      send(9, 8, 7, 6, 9, 8, 7, 6);
      in_valid = 0;
      drain();
      chk("no_bubble_run", 32'(run), 12);
      send(0, 1, 2, 3, 'h000, 'h001, 'h155, 'h003);
      send(4, 3, 2, 1, 'h004, 'h003, 'h155, 'h001);
      in_valid = 0;
      @(posedge clk); #1;
      nrst = 0;
      @(posedge clk); #1;
      chk("abort_out_valid", 32'(out_valid), 0);
      chk("abort_pending", 32'(sb.size()), 2);
      sb.delete();
      nrst = 1;
      @(posedge clk); #1;
      send(5, 2, 5, 2, 5, 2, 5, 2);
      in_valid = 0;
      drain();
      send(1, 1, 1, 1, 1, 1, 1, 1);
      in_valid = 0;
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
